btb_update_ctrl: RTL

Sequences all writes into the branch target buffer. Accepts branch-update requests from two pipeline requesters (resolve and commit), arbitrates and queues them, and coalesces same-PC updates so the BTB never receives two live ways with one tag. Issues at most one BTB load per cycle, defers loads while fetch holds the BTB, and sequences a full BTB flush. Sits between the execute/commit stages and the BTB write port.

---
 rtl/btb_pkg.sv | 26 ++
 rtl/btb_upd_queue.sv | 78 +++++++
 rtl/btb_update_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/btb_pkg.sv
// Shared BTB types: update record, branch-type encoding and field widths.
// Used by the BTB itself and by the update controller that writes it.
package btb_pkg;

  localparam int PC_W  = 29;
  localparam int TGT_W = 30;

  typedef enum logic [1:0] {
    BT_COND = 2'd0,
    BT_JUMP = 2'd1,
    BT_CALL = 2'd2,
    BT_RET  = 2'd3
  } btype_e;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [TGT_W-1:0] target;
    btype_e           btype;
  } btb_upd_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/btb_upd_queue.sv
// Circular update queue with a PC match port: a request whose PC is already
// queued overwrites that entry instead of allocating a new one.
module btb_upd_queue
  import btb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   enq,
  input  btb_upd_t               enq_data,
  input  logic                   deq,
  output btb_upd_t               head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  btb_upd_t        mem_r [DEPTH];
  logic [AW-1:0]   head_r;
  logic [AW-1:0]   tail_r;
  logic [AW:0]     count_r;
  logic [DEPTH-1:0] live_s;
  logic            match_s;
  logic [AW-1:0]   match_idx_s;
  logic            alloc_s;

  // Live-entry mask and PC match; the entry leaving this cycle never matches.
  always_comb begin
    match_s     = 1'b0;
    match_idx_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      live_s[i] = ({1'b0, (AW'(i) - head_r)} < count_r) &&
                  !(deq && (AW'(i) == head_r));
      if (live_s[i] && (mem_r[i].pc == enq_data.pc) && !match_s) begin
        match_s     = 1'b1;
        match_idx_s = AW'(i);
      end else begin
        match_s     = match_s;
        match_idx_s = match_idx_s;
      end
    end
  end

  assign alloc_s = enq & ~match_s;

  // Pointer, occupancy and storage update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (clr) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq && match_s) begin
        mem_r[match_idx_s] <= enq_data;
      end else if (enq) begin
        mem_r[tail_r] <= enq_data;
        tail_r        <= tail_r + 1'b1;
      end
      if (deq) begin
        head_r <= head_r + 1'b1;
      end
      count_r <= count_r + {{AW{1'b0}}, alloc_s} - {{AW{1'b0}}, deq};
    end
  end

  assign head_data = mem_r[head_r];
  assign count     = count_r;

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write sequencer: arbitrates resolve/commit updates into a coalescing
// queue, issues one filtered load per cycle and sequences BTB flushes.
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   r0_valid,
  output logic                   r0_ready,
  input  logic [PC_W-1:0]        r0_pc,
  input  logic [TGT_W-1:0]       r0_target,
  input  logic [1:0]             r0_btype,
  input  logic                   r1_valid,
  output logic                   r1_ready,
  input  logic [PC_W-1:0]        r1_pc,
  input  logic [TGT_W-1:0]       r1_target,
  input  logic [1:0]             r1_btype,
  input  logic                   hold,
  input  logic                   flush_req,
  output logic [PC_W-1:0]        btb_new_PC,
  output logic [TGT_W-1:0]       btb_new_target,
  output logic [1:0]             btb_new_btype,
  output logic                   btb_load,
  output logic                   btb_flush,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  ctrl_state_e state_r, next_state_s;
  logic        base_ready_s, acc0_s, acc1_s, enq_s;
  logic        clr_s, issue_s, filter_s;
  btb_upd_t    enq_data_s, head_s, data_r, last_r;
  logic        last_valid_r, btb_load_r, btb_flush_r;
  logic [CW-1:0] count_s;

  // Ready uses the registered count only, so a full queue never accepts.
  assign base_ready_s = ~rst & (state_r == ST_RUN) & ~flush_req &
                        (count_s < CW'(DEPTH));
  assign r0_ready = base_ready_s;
  assign r1_ready = base_ready_s & ~r0_valid;
  assign acc0_s   = r0_valid & r0_ready;
  assign acc1_s   = r1_valid & r1_ready;
  assign enq_s    = acc0_s | acc1_s;

  // Select the accepted requester's payload.
  always_comb begin
    enq_data_s = '0;
    if (acc0_s) begin
      enq_data_s.pc     = r0_pc;
      enq_data_s.target = r0_target;
      enq_data_s.btype  = btype_e'(r0_btype);
    end else begin
      enq_data_s.pc     = r1_pc;
      enq_data_s.target = r1_target;
      enq_data_s.btype  = btype_e'(r1_btype);
    end
  end

  btb_upd_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr_s),
    .enq       (enq_s),
    .enq_data  (enq_data_s),
    .deq       (issue_s),
    .head_data (head_s),
    .count     (count_s)
  );

  assign clr_s    = (state_r == ST_RUN) & flush_req;
  assign issue_s  = (state_r == ST_RUN) & ~flush_req & ~hold & (count_s != '0);
  assign filter_s = last_valid_r & (head_s == last_r);

  // Next-state logic; FLUSH lasts exactly one cycle.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (flush_req) begin
          next_state_s = ST_FLUSH;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_FLUSH: next_state_s = ST_RUN;
      default:  next_state_s = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Output and last-issued registers; a head equal to the last load is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r       <= '0;
      last_r       <= '0;
      last_valid_r <= 1'b0;
      btb_load_r   <= 1'b0;
      btb_flush_r  <= 1'b0;
    end else if (clr_s) begin
      last_valid_r <= 1'b0;
      btb_load_r   <= 1'b0;
      btb_flush_r  <= 1'b1;
    end else begin
      btb_flush_r <= 1'b0;
      if (issue_s && !filter_s) begin
        data_r       <= head_s;
        last_r       <= head_s;
        last_valid_r <= 1'b1;
        btb_load_r   <= 1'b1;
      end else begin
        btb_load_r <= 1'b0;
      end
    end
  end

  assign btb_new_PC     = data_r.pc;
  assign btb_new_target = data_r.target;
  assign btb_new_btype  = data_r.btype;
  assign btb_load       = btb_load_r;
  assign btb_flush      = btb_flush_r;
  assign q_count        = count_s;

endmodule
